victim_cache_control: RTL and testbench
=======================================

VICTIM_CACHE_CONTROL -- requirements
Module: victim_cache_control

Interface
REQ-001 SHALL have no parameters; entries fixed at 4 (lc3b_c_vic_index, 2 bits), tag width fixed at 12 (lc3b_c_vic_tag).
REQ-002 Ports SHALL be exactly:
  clk  in  1  system clock, all state updates on posedge
  reset  in  1  synchronous, active-high reset
  req_valid  in  1  L1 miss request, held high until resp
  req_tag  in  12  tag L1 is looking for
  req_has_victim  in  1  L1 is evicting a line with this request
  victim_tag  in  12  tag of line L1 evicts
  victim_dirty  in  1  evicted line is dirty
  resp  out  1  one-cycle completion pulse
  resp_hit  out  1  req_tag found in victim cache (valid with resp)
  resp_way  out  2  way hit or installed (valid with resp)
  tag0..tag3  in  12 each  current contents of victim tag array entries 0..3
  tag_load  out  1  write strobe to victim tag array
  data_load  out  1  write strobe to victim data array, same index
  vic_index  out  2  index to tag and data arrays
  vic_tag_in  out  12  tag written to tag array
  pmem_write  out  1  writeback request to L2, held until pmem_resp
  pmem_tag  out  12  tag of line being written back
  pmem_resp  in  1  L2 writeback complete
REQ-003 Clock SHALL be clk; reset SHALL be synchronous, active-high, named reset.

Function
REQ-004 SHALL hold internal valid[3:0], dirty[3:0], 2-bit age per way (0 = most recent), latched request fields, selected way.
REQ-005 FSM states SHALL be IDLE, COMPARE, WRITEBACK, INSTALL, RESPOND.
REQ-006 IDLE: req_valid=1 at posedge SHALL latch req_tag/req_has_victim/victim_tag/victim_dirty and go to COMPARE; req_valid in any other state SHALL be ignored.
REQ-007 COMPARE (exactly 1 cycle): hit[w] = valid[w] && tag_w==latched req_tag; multiple hits SHALL resolve to lowest w.
REQ-008 Hit, no victim: valid[way] SHALL clear at exit; touch LRU; go RESPOND with resp_hit=1.
REQ-009 Hit with victim (swap): way=hit way; go INSTALL; resp_hit=1.
REQ-010 Miss, no victim: no state change; go RESPOND with resp_hit=0, resp_way=0.
REQ-011 Miss with victim: way = lowest invalid way, else way with age 3; if valid[way]&&dirty[way] go WRITEBACK, else INSTALL; resp_hit=0.
REQ-012 WRITEBACK: pmem_write=1, pmem_tag=tag of way, held each cycle until pmem_resp=1 sampled, then INSTALL; pmem_resp outside WRITEBACK SHALL be ignored.
REQ-013 INSTALL (exactly 1 cycle): tag_load=1, data_load=1, vic_index=way, vic_tag_in=victim_tag; at exit valid[way]=1, dirty[way]=victim_dirty, touch LRU; go RESPOND.
REQ-014 RESPOND (exactly 1 cycle): resp=1, resp_hit, resp_way driven; go IDLE.
REQ-015 LRU touch of way w: ways with age < age[w] increment, age[w]=0; ages SHALL always remain a permutation of 0..3.
REQ-016 Latency from request acceptance edge: miss-no-victim/hit-no-victim resp 2 cycles later; install path 3 cycles later; writeback path 3 + cycles to pmem_resp.
REQ-017 tag_load, data_load, pmem_write, resp SHALL be 0 outside their states; vic_index SHALL equal way in all states.

Reset
REQ-018 reset SHALL force IDLE, valid=0, dirty=0, ages way0..3 = 0,1,2,3, way=0, all outputs 0, from any state including WRITEBACK (pmem_write drops next cycle).
REQ-019 reset SHALL take priority over every transition in the same cycle.

Verification
REQ-020 After reset, req_tag=0x123, no victim -> resp at +2 cycles, resp_hit=0, no tag_load.
REQ-021 Empty cache, 4 requests with victims 0xA00..0xA03 clean -> installs to ways 0,1,2,3 in order, each tag_load one cycle, resp_hit=0.
REQ-022 Full cache, request req_tag=0xA01 with victim 0xB00 -> resp_hit=1, resp_way=1, tag_load writes 0xB00 to index 1.
REQ-023 Full cache, ways all dirty, miss with victim -> pmem_write with pmem_tag=LRU way tag held 5 cycles until pmem_resp, then install to that way.
REQ-024 Hit without victim on way 2 -> valid[2] cleared; next miss with victim installs to way 2.
REQ-025 reset asserted during WRITEBACK -> IDLE next cycle, pmem_write=0, subsequent request sees empty cache.

Source files
------------

// File: rtl/victim_cache_control.sv
// Four-entry victim cache controller: tag compare, swap/install, dirty writeback and true-LRU replacement.
// Tag/data arrays live outside; this block only drives their strobes and index.
module victim_cache_control (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [11:0] req_tag,
  input  logic        req_has_victim,
  input  logic [11:0] victim_tag,
  input  logic        victim_dirty,
  output logic        resp,
  output logic        resp_hit,
  output logic [1:0]  resp_way,
  input  logic [11:0] tag0,
  input  logic [11:0] tag1,
  input  logic [11:0] tag2,
  input  logic [11:0] tag3,
  output logic        tag_load,
  output logic        data_load,
  output logic [1:0]  vic_index,
  output logic [11:0] vic_tag_in,
  output logic        pmem_write,
  output logic [11:0] pmem_tag,
  input  logic        pmem_resp
);

  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, INSTALL, RESPOND} state_t;

  state_t      state, nxt;
  logic [3:0]  valid, dirty;
  logic [1:0]  age [4];
  logic [11:0] l_req_tag, l_vtag;
  logic        l_hasv, l_vdirty;
  logic [1:0]  way, nxt_way;
  logic        hit_r, nxt_hit;
  logic [11:0] tags [4];
  logic [3:0]  hit;
  logic [1:0]  hit_way, repl_way, touch_way;
  logic        touch, clr_valid, install;

  assign tags[0] = tag0;
  assign tags[1] = tag1;
  assign tags[2] = tag2;
  assign tags[3] = tag3;

  // Lowest-index hit wins; replacement prefers lowest invalid way, else the age-3 way.
  always_comb begin
    hit      = '0;
    hit_way  = 2'd0;
    repl_way = 2'd0;
    for (int w = 0; w < 4; w++) hit[w] = valid[w] && (tags[w] == l_req_tag);
    for (int w = 3; w >= 0; w--) if (hit[w]) hit_way = w[1:0];
    for (int w = 3; w >= 0; w--) if (age[w] == 2'd3) repl_way = w[1:0];
    for (int w = 3; w >= 0; w--) if (!valid[w]) repl_way = w[1:0];
  end

  always_comb begin
    nxt       = state;
    nxt_way   = way;
    nxt_hit   = hit_r;
    touch     = 1'b0;
    touch_way = way;
    clr_valid = 1'b0;
    install   = 1'b0;
    case (state)
      IDLE: if (req_valid) nxt = COMPARE;
      COMPARE: begin
        if (|hit) begin
          nxt_way = hit_way;
          nxt_hit = 1'b1;
          if (l_hasv) nxt = INSTALL;
          else begin
            nxt       = RESPOND;
            clr_valid = 1'b1;
            touch     = 1'b1;
            touch_way = hit_way;
          end
        end else begin
          nxt_hit = 1'b0;
          if (l_hasv) begin
            nxt_way = repl_way;
            nxt     = (valid[repl_way] && dirty[repl_way]) ? WRITEBACK : INSTALL;
          end else begin
            nxt_way = 2'd0;
            nxt     = RESPOND;
          end
        end
      end
      WRITEBACK: if (pmem_resp) nxt = INSTALL;
      INSTALL: begin
        install = 1'b1;
        touch   = 1'b1;
        nxt     = RESPOND;
      end
      RESPOND: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      valid     <= '0;
      dirty     <= '0;
      way       <= 2'd0;
      hit_r     <= 1'b0;
      l_req_tag <= '0;
      l_vtag    <= '0;
      l_hasv    <= 1'b0;
      l_vdirty  <= 1'b0;
      for (int i = 0; i < 4; i++) age[i] <= i[1:0];
    end else begin
      state <= nxt;
      way   <= nxt_way;
      hit_r <= nxt_hit;
      if (state == IDLE && req_valid) begin
        l_req_tag <= req_tag;
        l_hasv    <= req_has_victim;
        l_vtag    <= victim_tag;
        l_vdirty  <= victim_dirty;
      end
      if (clr_valid) valid[touch_way] <= 1'b0;
      if (install) begin
        valid[way] <= 1'b1;
        dirty[way] <= l_vdirty;
      end
      // Younger-than-touched ways age by one; keeps ages a permutation of 0..3.
      if (touch)
        for (int i = 0; i < 4; i++)
          if (i[1:0] == touch_way) age[i] <= 2'd0;
          else if (age[i] < age[touch_way]) age[i] <= age[i] + 2'd1;
    end
  end

  assign resp       = (state == RESPOND);
  assign resp_hit   = resp && hit_r;
  assign resp_way   = resp ? way : 2'd0;
  assign tag_load   = (state == INSTALL);
  assign data_load  = (state == INSTALL);
  assign vic_index  = way;
  assign vic_tag_in = tag_load ? l_vtag : 12'h000;
  assign pmem_write = (state == WRITEBACK);
  assign pmem_tag   = pmem_write ? tags[way] : 12'h000;

endmodule

// File: tb/tb_victim_cache_control.sv
// Directed bench for victim_cache_control with a behavioural tag array model.
module tb_victim_cache_control;
  logic        clk = 1'b0, reset = 1'b0, req_valid = 1'b0, req_has_victim = 1'b0, victim_dirty = 1'b0, pmem_resp = 1'b0;
  logic [11:0] req_tag = '0, victim_tag = '0;
  logic        resp, resp_hit, tag_load, data_load, pmem_write;
  logic [1:0]  resp_way, vic_index;
  logic [11:0] vic_tag_in, pmem_tag;
  logic [11:0] tarr [4];

  int n_chk = 0, n_fail = 0;
  int lat, tl_n, pw_n;
  logic got, r_hit;
  logic [1:0] r_way, tl_idx;
  logic [11:0] tl_tag, pw_tag;

  victim_cache_control dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_tag(req_tag),
    .req_has_victim(req_has_victim), .victim_tag(victim_tag), .victim_dirty(victim_dirty),
    .resp(resp), .resp_hit(resp_hit), .resp_way(resp_way),
    .tag0(tarr[0]), .tag1(tarr[1]), .tag2(tarr[2]), .tag3(tarr[3]),
    .tag_load(tag_load), .data_load(data_load), .vic_index(vic_index), .vic_tag_in(vic_tag_in),
    .pmem_write(pmem_write), .pmem_tag(pmem_tag), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk)
    if (reset) for (int i = 0; i < 4; i++) tarr[i] <= '0;
    else if (tag_load) tarr[vic_index] <= vic_tag_in;

  // Issue one request, hold until resp, answer writeback after pdly pmem_write cycles.
  task automatic do_req(input logic [11:0] t, input logic hv, input logic [11:0] vt, input logic vd, input int pdly);
    @(posedge clk); #1;
    req_valid = 1'b1; req_tag = t; req_has_victim = hv; victim_tag = vt; victim_dirty = vd;
    lat = 0; tl_n = 0; pw_n = 0; got = 1'b0; r_hit = 1'b0; r_way = '0;
    tl_idx = '0; tl_tag = '0; pw_tag = '0;
    while (!got && lat < 50) begin
      @(posedge clk); #1; lat++;
      if (tag_load) begin
        tl_n++; tl_idx = vic_index; tl_tag = vic_tag_in;
        if (data_load !== 1'b1) begin n_fail++; $display("FAIL data_load: got %b want 1", data_load); end
      end
      if (pmem_write) begin pw_n++; pw_tag = pmem_tag; end
      pmem_resp = pmem_write && (pw_n == pdly);
      if (resp) begin got = 1'b1; r_hit = resp_hit; r_way = resp_way; end
    end
    req_valid = 1'b0; pmem_resp = 1'b0;
    n_chk++; if (!got) begin n_fail++; $display("FAIL resp_timeout: got no resp want resp within 50 cycles"); end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n_chk++; if ({resp, resp_hit, resp_way, tag_load, data_load, pmem_write} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outs: got %b want 0", {resp, resp_hit, resp_way, tag_load, data_load, pmem_write}); end
    n_chk++; if ({vic_index, vic_tag_in, pmem_tag} !== 26'b0) begin
      n_fail++; $display("FAIL reset_buses: got %h want 0", {vic_index, vic_tag_in, pmem_tag}); end
  endtask

  task automatic test_miss_no_victim;
    do_req(12'h123, 1'b0, 12'h000, 1'b0, 0);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL mnv_latency: got %0d want 2", lat); end
    n_chk++; if (r_hit !== 1'b0 || r_way !== 2'd0) begin n_fail++; $display("FAIL mnv_resp: got hit %b way %0d want 0 0", r_hit, r_way); end
    n_chk++; if (tl_n !== 0) begin n_fail++; $display("FAIL mnv_tag_load: got %0d want 0", tl_n); end
  endtask

  task automatic test_fill(input logic [11:0] base, input logic vd);
    for (int i = 0; i < 4; i++) begin
      do_req(12'h777, 1'b1, base + 12'(i), vd, 0);
      n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL fill%0d_latency: got %0d want 3", i, lat); end
      n_chk++; if (tl_n !== 1 || tl_idx !== 2'(i) || tl_tag !== base + 12'(i)) begin
        n_fail++; $display("FAIL fill%0d_install: got n %0d idx %0d tag %h want 1 %0d %h", i, tl_n, tl_idx, tl_tag, i, base + 12'(i)); end
      n_chk++; if (r_hit !== 1'b0 || pw_n !== 0) begin n_fail++; $display("FAIL fill%0d_resp: got hit %b pw %0d want 0 0", i, r_hit, pw_n); end
    end
  endtask

  task automatic test_swap;
    do_req(12'hA01, 1'b1, 12'hB00, 1'b0, 0);
    n_chk++; if (r_hit !== 1'b1 || r_way !== 2'd1) begin n_fail++; $display("FAIL swap_resp: got hit %b way %0d want 1 1", r_hit, r_way); end
    n_chk++; if (tl_n !== 1 || tl_idx !== 2'd1 || tl_tag !== 12'hB00) begin
      n_fail++; $display("FAIL swap_install: got n %0d idx %0d tag %h want 1 1 b00", tl_n, tl_idx, tl_tag); end
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL swap_latency: got %0d want 3", lat); end
  endtask

  // Dirty fill leaves ages 3,2,1,0 so way 0 (0xD00) is the writeback target.
  task automatic test_writeback;
    do_req(12'h555, 1'b1, 12'hE00, 1'b1, 5);
    n_chk++; if (pw_n !== 5 || pw_tag !== 12'hD00) begin n_fail++; $display("FAIL wb_pmem: got n %0d tag %h want 5 d00", pw_n, pw_tag); end
    n_chk++; if (tl_n !== 1 || tl_idx !== 2'd0 || tl_tag !== 12'hE00) begin
      n_fail++; $display("FAIL wb_install: got n %0d idx %0d tag %h want 1 0 e00", tl_n, tl_idx, tl_tag); end
    n_chk++; if (lat !== 8 || r_hit !== 1'b0) begin n_fail++; $display("FAIL wb_resp: got lat %0d hit %b want 8 0", lat, r_hit); end
  endtask

  task automatic test_hit_clear;
    do_req(12'hD02, 1'b0, 12'h000, 1'b0, 0);
    n_chk++; if (r_hit !== 1'b1 || r_way !== 2'd2 || lat !== 2 || tl_n !== 0) begin
      n_fail++; $display("FAIL hc_hit: got hit %b way %0d lat %0d tl %0d want 1 2 2 0", r_hit, r_way, lat, tl_n); end
    do_req(12'hD02, 1'b0, 12'h000, 1'b0, 0);
    n_chk++; if (r_hit !== 1'b0 || r_way !== 2'd0) begin n_fail++; $display("FAIL hc_recheck: got hit %b way %0d want 0 0", r_hit, r_way); end
    do_req(12'h777, 1'b1, 12'hF00, 1'b0, 0);
    n_chk++; if (pw_n !== 0 || tl_idx !== 2'd2 || tl_tag !== 12'hF00 || lat !== 3) begin
      n_fail++; $display("FAIL hc_refill: got pw %0d idx %0d tag %h lat %0d want 0 2 f00 3", pw_n, tl_idx, tl_tag, lat); end
  endtask

  // Way 1 (0xD01, dirty) is now LRU; reset mid-writeback must abandon it.
  task automatic test_reset_in_wb;
    @(posedge clk); #1;
    req_valid = 1'b1; req_tag = 12'h999; req_has_victim = 1'b1; victim_tag = 12'hC00; victim_dirty = 1'b1;
    repeat (2) @(posedge clk); #1;
    req_valid = 1'b0;
    n_chk++; if (pmem_write !== 1'b1 || pmem_tag !== 12'hD01) begin
      n_fail++; $display("FAIL rwb_enter: got pw %b tag %h want 1 d01", pmem_write, pmem_tag); end
    reset = 1'b1; pmem_resp = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; pmem_resp = 1'b0;
    n_chk++; if (pmem_write !== 1'b0 || resp !== 1'b0 || tag_load !== 1'b0) begin
      n_fail++; $display("FAIL rwb_drop: got pw %b resp %b tl %b want 0 0 0", pmem_write, resp, tag_load); end
    do_req(12'hD03, 1'b0, 12'h000, 1'b0, 0);
    n_chk++; if (r_hit !== 1'b0 || lat !== 2) begin n_fail++; $display("FAIL rwb_empty: got hit %b lat %0d want 0 2", r_hit, lat); end
    do_req(12'h888, 1'b1, 12'hC01, 1'b0, 0);
    n_chk++; if (tl_idx !== 2'd0 || pw_n !== 0) begin n_fail++; $display("FAIL rwb_install: got idx %0d pw %0d want 0 0", tl_idx, pw_n); end
  endtask

  initial begin
    test_reset;
    test_miss_no_victim;
    test_fill(12'hA00, 1'b0);
    test_swap;
    test_reset;
    test_fill(12'hD00, 1'b1);
    test_writeback;
    test_hit_clear;
    test_reset_in_wb;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
